// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the CORDIC rotation frontend.
// Angle constants are Q3.13 (Width = 16) and are sign-extended by users
// when a wider datapath is configured.
package cordic_pkg;

    localparam int unsigned QWidth = 16;

    localparam logic signed [QWidth-1:0] PI_Q      = 16'sd25736;  // 0x6488
    localparam logic signed [QWidth-1:0] HALF_PI_Q = 16'sd12868;  // 0x3244
    localparam logic signed [QWidth-1:0] K_GAIN_Q  = 16'sd4975;   // 0x136F, 1/K

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/cordic_range_reduce.sv
// Combinational angle fold into [-PI/2, +PI/2].
//   theta_i : signed angle, Q3.(Width-3)
//   z_o     : reduced angle for the core
//   flip_o  : result must be negated (angle was folded by +/-PI)
//   oor_o   : angle outside [-PI, +PI]
module cordic_range_reduce
    import cordic_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] theta_i,
    output logic [Width-1:0] z_o,
    output logic             flip_o,
    output logic             oor_o
);

    localparam logic signed [Width-1:0] PiW     = Width'(PI_Q);
    localparam logic signed [Width-1:0] HalfPiW = Width'(HALF_PI_Q);

    logic signed [Width-1:0] theta_s;
    assign theta_s = $signed(theta_i);

    // Exactly +/-HALF_PI stays unreduced; the core converges there.
    always_comb begin
        z_o    = theta_i;
        flip_o = 1'b0;
        oor_o  = (theta_s > PiW) || (theta_s < -PiW);
        if (theta_s > HalfPiW) begin
            z_o    = Width'(theta_s - PiW);
            flip_o = 1'b1;
        end else if (theta_s < -HalfPiW) begin
            z_o    = Width'(theta_s + PiW);
            flip_o = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_rotate_frontend.sv
// Request sequencer and range-reduction stage in front of an iterative
// CORDIC core. Takes one angle per request, seeds and starts the core,
// waits for done (with watchdog), sign-corrects and returns cos/sin.
//   clk_i, rst_i (async, active-low)
//   req_valid_i/req_ready_o/theta_i        : angle request
//   res_valid_o/res_ready_i/cos_o/sin_o/res_err_o : result
//   start_cordic_o, x0_o, y0_o, z0_o        : core launch
//   xn_i, yn_i, done_tick_cordic_i          : core completion
module cordic_rotate_frontend
    import cordic_pkg::*;
#(
    parameter int unsigned Width         = 16,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [Width-1:0] theta_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [Width-1:0] cos_o,
    output logic [Width-1:0] sin_o,
    output logic             res_err_o,
    output logic             start_cordic_o,
    output logic [Width-1:0] x0_o,
    output logic [Width-1:0] y0_o,
    output logic [Width-1:0] z0_o,
    input  logic [Width-1:0] xn_i,
    input  logic [Width-1:0] yn_i,
    input  logic             done_tick_cordic_i
);

    localparam int unsigned WdWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(TimeoutCycles - 1);
    localparam logic [Width-1:0]   KGainW = Width'(K_GAIN_Q);

    state_e             state_q, state_d;
    logic [WdWidth-1:0] wd_q, wd_d;
    logic               flip_q, flip_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic [Width-1:0]   cos_q, cos_d, sin_q, sin_d;
    logic [Width-1:0]   x0_q, x0_d, y0_q, y0_d, z0_q, z0_d;

    logic [Width-1:0]   z_red;
    logic               flip_red, oor_red;

    cordic_range_reduce #(.Width(Width)) u_reduce (
        .theta_i (theta_i),
        .z_o     (z_red),
        .flip_o  (flip_red),
        .oor_o   (oor_red)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        flip_d  = flip_q;
        err_d   = err_q;
        start_d = 1'b0;
        cos_d   = cos_q;
        sin_d   = sin_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        z0_d    = z0_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    flip_d = flip_red;
                    if (oor_red) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        cos_d   = '0;
                        sin_d   = '0;
                    end else begin
                        state_d = ST_LOAD;
                        start_d = 1'b1;
                        x0_d    = KGainW;
                        y0_d    = '0;
                        z0_d    = z_red;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
                wd_d    = '0;
            end
            ST_WAIT: begin
                // Done wins over an expiring watchdog in the same cycle.
                if (done_tick_cordic_i) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    cos_d   = flip_q ? -xn_i : xn_i;
                    sin_d   = flip_q ? -yn_i : yn_i;
                end else if (wd_q == WdLast) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    cos_d   = '0;
                    sin_d   = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
            flip_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            z0_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            flip_q  <= flip_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            start_q <= start_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            z0_q    <= z0_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign res_valid_o    = valid_q;
    assign res_err_o      = err_q;
    assign start_cordic_o = start_q;
    assign cos_o          = cos_q;
    assign sin_o          = sin_q;
    assign x0_o           = x0_q;
    assign y0_o           = y0_q;
    assign z0_o           = z0_q;

endmodule

// File: doc/cordic_rotate_frontend.md
# cordic_rotate_frontend

Request sequencer and angle range-reduction stage directly upstream of the iterative `cordic` core.
- Accepts one signed angle per valid/ready transaction.
- Folds the angle into the core's convergence range, loads gain-compensated seeds and pulses the core's start.
- Waits for the core's done tick, then applies the quadrant sign correction.
- Returns cos/sin through a valid/ready result port, with a watchdog against a hung core.

## Interface
Parameters:
- `Width`, 16, datapath width; angles and results are signed Q3.(Width-3).
- `TimeoutCycles`, 64, maximum cycles in WAIT before the watchdog aborts.

Ports:
- `clk_i`, input, 1, clock.
- `rst_i`, input, 1, asynchronous active-low reset.
- `req_valid_i`, input, 1, angle request valid.
- `req_ready_o`, output, 1, frontend can accept a request.
- `theta_i`, input, Width, signed angle in radians.
- `res_valid_o`, output, 1, result valid.
- `res_ready_i`, input, 1, consumer accepts the result.
- `cos_o`, output, Width, signed cosine.
- `sin_o`, output, Width, signed sine.
- `res_err_o`, output, 1, result is invalid (out-of-range angle or timeout); qualified by `res_valid_o`.
- `start_cordic_o`, output, 1, one-cycle start pulse to the core.
- `x0_o`, output, Width, core x seed.
- `y0_o`, output, Width, core y seed.
- `z0_o`, output, Width, core z seed.
- `xn_i`, input, Width, core x result.
- `yn_i`, input, Width, core y result.
- `done_tick_cordic_i`, input, 1, core completion tick.

## Operation
- FSM states: IDLE, LOAD, WAIT, RESP.
  - `req_ready_o` = 1 only in IDLE.
  - `res_valid_o` = 1 only in RESP.
- IDLE: on `req_valid_i & req_ready_o`, register the reduced angle and the flip flag.
  - Out-of-range angle (theta > PI or theta < -PI): go to RESP with err=1 and cos/sin = 0. The core is not started.
  - Otherwise go to LOAD.
- Range reduction, all comparisons signed:
  - theta > HALF_PI: z = theta - PI, flip = 1.
  - theta < -HALF_PI: z = theta + PI, flip = 1.
  - Else z = theta, flip = 0.
  - Exactly ±HALF_PI is not reduced.
- LOAD (one cycle): `start_cordic_o` = 1; `x0_o` = K_GAIN, `y0_o` = 0, `z0_o` = z. Next state is WAIT.
- Seeds are registered outputs and stay stable from LOAD until the next request.
- WAIT: a watchdog counter increments every cycle.
  - `done_tick_cordic_i` = 1: capture the result, go to RESP, err = 0. Done takes priority over the watchdog in the same cycle.
  - Result capture: `cos_o` = flip ? -xn_i : xn_i; `sin_o` = flip ? -yn_i : yn_i. Negation is two's complement and never overflows, because |result| ≤ 1.0.
  - Counter reaches TimeoutCycles-1 without done: go to RESP, err = 1, cos/sin = 0.
- RESP: outputs are held stable while `res_ready_i` = 0. `res_valid_o & res_ready_i` returns to IDLE.
- A done tick arriving outside WAIT is ignored.

## Timing
- Reset, asynchronous, active-low:
  - FSM to IDLE.
  - `req_ready_o` = 1 (IDLE).
  - `res_valid_o`, `res_err_o`, `start_cordic_o` = 0.
  - `cos_o`, `sin_o`, `x0_o`, `y0_o`, `z0_o` = 0.
  - Watchdog = 0.
- Reset mid-operation aborts the transaction with no result. A done tick still pending from the core is ignored.
- Request accepted at edge T: `start_cordic_o` is high during cycle T+1 (LOAD); WAIT starts at T+2.
- Done tick sampled at edge D: `res_valid_o` is high from cycle D+1.
- Total latency = core latency + 3 cycles.
- Out-of-range request accepted at T: `res_valid_o` is high from T+1 with err = 1.
- Throughput: one transaction in flight. The next request can be accepted in the cycle after the result handshake.

## Structure
- Package `cordic_pkg` holds:
  - Q-format constants for Width=16: PI = 25736 (0x6488), HALF_PI = 12868 (0x3244), K_GAIN = 4975 (0x136F).
  - FSM state enum.
- One natural sub-module: `cordic_range_reduce`, combinational. It maps theta to {z, flip, out_of_range}.
- The FSM, watchdog and output registers stay in the top.

## Test plan
- theta = 0 with an ideal core model → cos = 8192 ±8 LSB, sin = 0 ±8; start pulse lasts exactly one cycle; `z0_o` = 0.
- theta = 17157 (2π/3) → `z0_o` = -8579, flip = 1; cos ≈ -4096 ±8, sin ≈ 7094 ±8.
- theta = 12868 (exactly HALF_PI) → no reduction: `z0_o` = 12868, sin ≈ 8192 ±8. theta = -25736 → `z0_o` = 0, cos ≈ -8192 ±8.
- theta = 26000 → no start pulse; `res_valid_o` at T+1 with err = 1, cos = sin = 0.
- Core never asserts done → `res_valid_o` with err = 1 exactly TimeoutCycles cycles after WAIT entry. Done in the final cycle → err = 0.
- Hold `res_ready_i` = 0 for 5 cycles → result stable and `req_ready_o` = 0 throughout. Assert `rst_i` = 0 in WAIT → all outputs 0 immediately, and a later done tick is ignored.
